// File: rtl/data_memory_sized.sv
// Byte-addressed big-endian data memory for the MEM stage: sized stores, sign/zero-extended
// registered loads with a valid strobe, misalignment strobe and a post-reset preload sequencer.
module data_memory_sized #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          INIT_WORDS = 10,
  parameter logic [31:0] INIT_VALUE = 32'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_start,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic        ready,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        misaligned,
  output logic        init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((INIT_WORDS > 0) ? (INIT_WORDS - 1) : 0);
  localparam logic HAS_INIT = (INIT_WORDS > 0);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  init_done_q;
  logic                  read_valid_q;
  logic                  misaligned_q;
  logic [31:0]           read_data_q;
  logic [7:0]            mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] addr_s;
  logic [ADDR_WIDTH-1:0] wbase_s;
  logic [ADDR_WIDTH-1:0] init_addr_s;
  logic [ADDR_WIDTH-1:0] rlane_s [4];
  logic [ADDR_WIDTH-1:0] wlane_s [4];
  logic [31:0]           rbytes_s;
  logic [31:0]           wword_s;
  logic [3:0]            wen_s;
  logic                  mis_s;
  logic                  req_s;
  logic                  rd_acc_s;
  logic                  wr_acc_s;
  logic                  unused_s;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lsb);
    logic r;
    case (sz)
      2'b00:   r = 1'b0;
      2'b01:   r = lsb[0];
      default: r = (lsb != 2'b00);
    endcase
    return r;
  endfunction

  // Lane 0 (lowest address) sits in bits [31:24] of be; byte/half results come from the top.
  function automatic logic [31:0] load_format(input logic [1:0] sz, input logic uns,
                                              input logic [31:0] be);
    logic [31:0] r;
    case (sz)
      2'b00:   r = uns ? {24'h000000, be[31:24]} : {{24{be[31]}}, be[31:24]};
      2'b01:   r = uns ? {16'h0000, be[31:16]} : {{16{be[31]}}, be[31:16]};
      default: r = be;
    endcase
    return r;
  endfunction

  assign addr_s      = address[ADDR_WIDTH-1:0];
  assign unused_s    = ^address[31:ADDR_WIDTH];
  assign init_addr_s = ADDR_WIDTH'({cnt_q, 2'b00});
  assign mis_s       = is_misaligned(size, addr_s[1:0]);
  assign req_s       = ready_q & (mem_read | mem_write);
  assign rd_acc_s    = req_s & mem_read & ~mis_s;
  assign wr_acc_s    = req_s & mem_write & ~mis_s;

  // Per-lane byte addresses for the load and store ports, wrapping modulo depth.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rlane_s[k] = addr_s + ADDR_WIDTH'(k);
      wlane_s[k] = wbase_s + ADDR_WIDTH'(k);
    end
  end

  assign rbytes_s = {mem_q[rlane_s[0]], mem_q[rlane_s[1]], mem_q[rlane_s[2]], mem_q[rlane_s[3]]};

  // Store port: preload words while initialising, otherwise accepted aligned stores.
  always_comb begin
    wbase_s = addr_s;
    wword_s = write_data;
    wen_s   = 4'b0000;
    if (state_q == ST_INIT) begin
      wbase_s = init_addr_s;
      wword_s = INIT_VALUE;
      if (HAS_INIT && !init_start) begin
        wen_s = 4'b1111;
      end else begin
        wen_s = 4'b0000;
      end
    end else if (wr_acc_s) begin
      case (size)
        2'b00: begin
          wword_s = {write_data[7:0], 24'h000000};
          wen_s   = 4'b0001;
        end
        2'b01: begin
          wword_s = {write_data[15:0], 16'h0000};
          wen_s   = 4'b0011;
        end
        default: begin
          wword_s = write_data;
          wen_s   = 4'b1111;
        end
      endcase
    end else begin
      wen_s = 4'b0000;
    end
  end

  // Byte array has no reset so its contents survive rst_n; writes are blocked while in reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst_n && wen_s[k]) begin
        mem_q[wlane_s[k]] <= wword_s[31-8*k -: 8];
      end
    end
  end

  // Preload sequencer next state; init_start wins from any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (init_start) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (!HAS_INIT || (cnt_q == LAST_CNT)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      endcase
    end
    ready_d = (state_d == ST_IDLE);
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      init_done_q  <= 1'b0;
      read_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      read_data_q  <= 32'h00000000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      init_done_q  <= ready_d;
      read_valid_q <= rd_acc_s;
      misaligned_q <= req_s & mis_s;
      if (rd_acc_s) begin
        read_data_q <= load_format(size, unsigned_ld, rbytes_s);
      end else begin
        read_data_q <= read_data_q;
      end
    end
  end

  assign ready      = ready_q;
  assign init_done  = init_done_q;
  assign read_valid = read_valid_q;
  assign misaligned = misaligned_q;
  assign read_data  = read_data_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: a byte-array reference model predicts each
// accepted request's response; a negedge monitor pops and compares strobes and held data.
module tb_data_memory_sized;

  localparam int          AW    = 8;
  localparam int          DEPTH = 256;
  localparam int          IW    = 10;
  localparam logic [31:0] IV    = 32'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_start;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic        ready;
  logic [31:0] read_data;
  logic        read_valid;
  logic        misaligned;
  logic        init_done;

  data_memory_sized #(.ADDR_WIDTH(AW), .INIT_WORDS(IW), .INIT_VALUE(IV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_start (init_start),
    .address    (address),
    .write_data (write_data),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .size       (size),
    .unsigned_ld(unsigned_ld),
    .ready      (ready),
    .read_data  (read_data),
    .read_valid (read_valid),
    .misaligned (misaligned),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          init_left = 0;
  logic [31:0] hold_val = 32'h0;
  logic [7:0]  mdl_mem [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
  endfunction

  function automatic bit mdl_mis(input logic [1:0] sz, input int a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [1:0] sz, input int a, input bit uns);
    int n = nbytes(sz);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(mdl_mem[(a + i) % DEPTH]);
    if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mdl_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) mdl_mem[(a + i) % DEPTH] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  task automatic mdl_preload();
    for (int w = 0; w < IW; w++)
      for (int b = 0; b < 4; b++) mdl_mem[4*w + b] = 8'(IV >> (8 * (3 - b)));
  endtask

  // Drive one cycle's request (called at posedge+2), predict its outcome, advance a cycle.
  task automatic op(input bit rd, input bit wr, input logic [1:0] sz, input logic [31:0] addr,
                    input logic [31:0] wd, input bit uns, input bit ist);
    bit   rdy_m;
    int   a;
    exp_t e;
    mem_read    = rd;
    mem_write   = wr;
    size        = sz;
    address     = addr;
    write_data  = wd;
    unsigned_ld = uns;
    init_start  = ist;
    rdy_m = (init_left == 0);
    check("ready", 32'(ready), 32'(rdy_m));
    check("init_done", 32'(init_done), 32'(rdy_m));
    if (rdy_m && (rd || wr)) begin
      a     = int'(addr[AW-1:0]);
      e.due = cyc + 1;
      if (mdl_mis(sz, a)) begin
        e.is_rd = 1'b0;
        e.data  = 32'h0;
        exp_q.push_back(e);
      end else begin
        if (rd) begin
          e.is_rd = 1'b1;
          e.data  = mdl_load(sz, a, uns);
          exp_q.push_back(e);
        end
        if (wr) mdl_store(sz, a, wd);
      end
    end
    if (ist) begin
      mdl_preload();
      init_left = IW;
    end else if (init_left > 0) begin
      init_left--;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic drive_idle();
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    init_start  = 1'b0;
    size        = 2'b00;
    address     = 32'h0;
    write_data  = 32'h0;
    unsigned_ld = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_init_done", 32'(init_done), 32'h0);
    check("rst_read_valid", 32'(read_valid), 32'h0);
    check("rst_misaligned", 32'(misaligned), 32'h0);
    check("rst_read_data", read_data, 32'h0);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear before any further clock edge.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    drive_idle();
    exp_q.delete();
    hold_val = 32'h0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    mdl_preload();
    init_left = IW;
  endtask

  // Monitor: every strobe must match the head of the scoreboard in its due cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (read_valid || misaligned) begin
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_strobe: read_valid=%b misaligned=%b with nothing due (cycle %0d)",
                   read_valid, misaligned, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind", {30'd0, read_valid, misaligned},
                mon_e.is_rd ? 32'h2 : 32'h1);
          if (mon_e.is_rd) hold_val = mon_e.data;
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL missing_strobe: no strobe, expected %s data %h (cycle %0d)",
                 mon_e.is_rd ? "read_valid" : "misaligned", mon_e.data, cyc);
      end
      check("read_data", read_data, hold_val);
    end
  end

  initial begin
    logic [31:0] addr;
    logic [1:0]  sz;
    int          r;
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs();
    rst_n = 1'b1;
    mdl_preload();
    init_left = IW;

    // Requests during preload are dropped.
    op(1'b0, 1'b1, 2'b10, 32'h40, 32'hCAFEF00D, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b10, 32'h24, 32'h0, 1'b0, 1'b0);
    idle(8);

    op(1'b1, 1'b0, 2'b10, 32'h24, 32'h0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 2'b10, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 2'b00, 32'h40 + 32'(i), 32'h0, 1'b1, 1'b0);
    op(1'b1, 1'b0, 2'b00, 32'h40, 32'h0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b01, 32'h42, 32'h0, 1'b1, 1'b0);
    op(1'b1, 1'b0, 2'b01, 32'h42, 32'h0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 2'b10, 32'h41, 32'h11111111, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b10, 32'h40, 32'h0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b01, 32'h43, 32'h0, 1'b0, 1'b0);
    op(1'b1, 1'b1, 2'b10, 32'h40, 32'h12345678, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b10, 32'hABCD0040, 32'h0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 2'b10, 32'h00, 32'h0, 1'b0, 1'b0);
    op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(IW);
    op(1'b1, 1'b0, 2'b10, 32'h00, 32'h0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 2'b10, 32'hFC, 32'hA5A55ADA, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b10, 32'hFC, 32'h0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b00, 32'hFF, 32'h0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b01, 32'hFE, 32'h0, 1'b0, 1'b0);

    // Reset while a load response is in flight.
    op(1'b1, 1'b0, 2'b10, 32'h24, 32'h0, 1'b0, 1'b0);
    do_reset();
    idle(IW);

    for (int w = 0; w < DEPTH / 4; w++)
      op(1'b0, 1'b1, 2'b10, 32'(4 * w), $urandom, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      r    = $urandom_range(0, 9);
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      op((r <= 3) || (r == 7), (r >= 4) && (r <= 7), sz, addr, $urandom,
         1'($urandom_range(0, 1)), $urandom_range(0, 149) == 0);
    end
    idle(IW);

    // Reset in the middle of a restarted preload.
    op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(3);
    do_reset();
    idle(IW);
    op(1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 1'b0);
    idle(3);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised successor of the pipeline's byte-addressed data memory; sits in the MEM stage between the ALU result and the writeback mux.
- Adds sized accesses (byte/half/word) with big-endian byte lanes, sign/zero-extended loads and a registered read with a valid strobe.
- Adds misalignment detection and a reset-driven init sequencer that replaces the edge-triggered preload.

Parameters:
- ADDR_WIDTH, 8, byte-address bits used; depth = 2^ADDR_WIDTH bytes.
- INIT_WORDS, 10, number of words preloaded after reset or init_start, from byte 0 upward.
- INIT_VALUE, 32'd5, word value written to each preloaded word.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- init_start  in  1  one-cycle pulse; restarts the preload sequence.
- address  in  32  byte address; bits above ADDR_WIDTH-1 are ignored (modulo depth).
- write_data  in  32  store data, right-justified for byte/half stores.
- mem_write  in  1  store request.
- mem_read  in  1  load request.
- size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- unsigned_ld  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- ready  out  1  accepts requests; low during init.
- read_data  out  32  registered load result.
- read_valid  out  1  one-cycle strobe; read_data is valid in that cycle.
- misaligned  out  1  one-cycle strobe; accepted request was misaligned.
- init_done  out  1  high once preload completes; cleared by reset or init_start.

Behaviour:
- Reset values:
  - ready=0, read_data=0, read_valid=0, misaligned=0, init_done=0.
  - FSM in INIT with counter=0.
  - Memory array is not cleared.
- FSM states are INIT and IDLE.
  - INIT: each cycle writes INIT_VALUE to bytes 4*cnt..4*cnt+3 (MSB at the lowest address) and increments cnt.
  - When cnt==INIT_WORDS-1 is written, go to IDLE and set init_done=1 and ready=1 on the next cycle.
  - INIT_WORDS=0: go to IDLE on the first clock after reset.
  - IDLE: ready=1.
  - init_start in any state: go to INIT, set cnt=0, init_done=0, ready=0 from the next cycle.
  - init_start during INIT restarts the count.
- Requests are sampled only when ready=1. A request sampled with ready=0 is dropped: no write, no strobe.
- Alignment rules:
  - half is misaligned if addr[0]=1.
  - word is misaligned if addr[1:0]!=0.
  - byte is never misaligned.
  - A misaligned request (read or write) writes nothing and produces no read_valid.
  - misaligned is pulsed for 1 cycle after acceptance; read_data is unchanged.
- Store (big-endian):
  - byte: mem[a]=wd[7:0].
  - half: mem[a]=wd[15:8], mem[a+1]=wd[7:0].
  - word: mem[a..a+3]=wd[31:24..7:0].
  - The write takes effect at the accepting clock edge.
- Load:
  - Latency is 1 cycle: the request is accepted at edge N; read_data and read_valid=1 are presented after edge N.
  - read_valid is high for one cycle only.
  - read_data holds its value until the next valid load.
  - Byte/half results are extended per unsigned_ld.
- Simultaneous mem_read and mem_write at the same address:
  - The write is performed.
  - The read returns the pre-write contents (read-before-write).
  - read_valid is still pulsed.
- Back-to-back loads every cycle are supported: read_valid stays high continuously.
- Asynchronous reset mid-INIT or mid-access aborts immediately. All outputs take their reset values; preload restarts after rst_n rises.
- The top word (address 2^ADDR_WIDTH-4) is accessible. Aligned accesses never cross the top boundary.

Test Plan:
- Release rst_n -> ready=0 for INIT_WORDS=10 cycles, then ready=1 and init_done=1. A word load at 0x24 returns 0x00000005 one cycle later with read_valid=1.
- Word store 0xDEADBEEF at 0x40, then byte loads at 0x40..0x43 with unsigned_ld=1 -> 0xDE, 0xAD, 0xBE, 0xEF.
- Byte load at 0x40, signed -> 0xFFFFFFDE. Half load at 0x42, unsigned -> 0x0000BEEF. Half load at 0x42, signed -> 0xFFFFBEEF.
- Word store at 0x41 -> misaligned pulses 1 cycle, no read_valid; a word load at 0x40 then still returns 0xDEADBEEF. A half load at 0x43 -> misaligned=1.
- Same-cycle word read+write at 0x40 with wd=0x12345678 -> read_data=0xDEADBEEF. The next load returns 0x12345678.
- Pulse init_start after writing 0x0 to 0x00 -> ready drops for 10 cycles and init_done clears; the load at 0x00 afterwards returns 0x5. Assert rst_n=0 mid-INIT -> outputs go to reset values immediately.
